// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// The control-word priority (freeze > stall > flush > normal) lives in one helper.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam pipe_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // A pending branch is dropped under a stall: it is re-resolved next cycle.
    function automatic pipe_ctrl_t sel_ctrl(input logic miss, input logic stall,
                                            input logic flush);
        pipe_ctrl_t c;
        if (miss)       c = CTRL_FREEZE;
        else if (stall) c = CTRL_STALL;
        else if (flush) c = CTRL_FLUSH;
        else            c = CTRL_NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the debug event counts.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {W{1'b1}})) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: merges load-use stall, branch flush and
// data-memory wait into per-stage enables, with start-up hold and wait timeout.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             hazard_stall_i,
    input  logic             branch_flush_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             memwb_bubble_o,
    output logic [1:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o
);

    state_t           state_reg;
    logic [TMO_W-1:0] timer_reg;
    logic             timeout_reg;

    logic       miss;
    logic       active;
    logic       timeout_hit;
    pipe_ctrl_t ctrl;

    assign miss        = dmem_req_i & ~dmem_ack_i;
    assign active      = (state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (timer_reg == TMO_W'(MEM_TIMEOUT));

    always_comb begin
        ctrl = CTRL_HOLD;
        if (active) begin
            ctrl = sel_ctrl(miss, hazard_stall_i, branch_flush_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (miss) begin
                        state_reg <= ST_MEM_WAIT;
                        timer_reg <= TMO_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!miss) begin
                        state_reg <= ST_RUN;
                        timer_reg <= '0;
                    end else if (timeout_hit) begin
                        state_reg   <= ST_HALT;
                        timeout_reg <= 1'b1;
                    end else if (timer_reg != {TMO_W{1'b1}}) begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: ;  // HALT is left only through reset
            endcase
        end
    end

    // Index 0 = stall, 1 = flush, 2 = freeze; each fires on the cycle its control wins.
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_q [3];

    assign cnt_inc[0] = active & ~miss & hazard_stall_i;
    assign cnt_inc[1] = active & ~miss & ~hazard_stall_i & branch_flush_i;
    assign cnt_inc[2] = active & miss;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk_i),
                .rst_n (rst_i),
                .inc   (cnt_inc[gi]),
                .clr   (state_reg == ST_IDLE),
                .q     (cnt_q[gi])
            );
        end
    endgenerate

    assign pc_write_o     = ctrl.pc_write;
    assign ifid_write_o   = ctrl.ifid_write;
    assign ifid_flush_o   = ctrl.ifid_flush;
    assign idex_bubble_o  = ctrl.idex_bubble;
    assign exmem_write_o  = ctrl.exmem_write;
    assign memwb_bubble_o = ctrl.memwb_bubble;
    assign state_o        = state_reg;
    assign timeout_o      = timeout_reg;
    assign stall_cnt_o    = cnt_q[0];
    assign flush_cnt_o    = cnt_q[1];
    assign wait_cnt_o     = cnt_q[2];

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with hand-computed expectations.
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 4;

    // Control word order: {pc, ifid, ifid_flush, idex_bubble, exmem, memwb_bubble}
    localparam logic [5:0] E_HOLD   = 6'b000101;
    localparam logic [5:0] E_FREEZE = 6'b000001;
    localparam logic [5:0] E_STALL  = 6'b000110;
    localparam logic [5:0] E_FLUSH  = 6'b111010;
    localparam logic [5:0] E_NORMAL = 6'b110010;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic start_i = 1'b0, hazard_stall_i = 1'b0, branch_flush_i = 1'b0;
    logic dmem_req_i = 1'b0, dmem_ack_i = 1'b0;
    logic pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
    logic exmem_write_o, memwb_bubble_o, timeout_o;
    logic [1:0] state_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;
    logic [5:0] ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .TMO_W(8), .MEM_TIMEOUT(5)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .hazard_stall_i (hazard_stall_i),
        .branch_flush_i (branch_flush_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_ack_i     (dmem_ack_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .exmem_write_o  (exmem_write_o),
        .memwb_bubble_o (memwb_bubble_o),
        .state_o        (state_o),
        .timeout_o      (timeout_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .wait_cnt_o     (wait_cnt_o)
    );

    assign ctrl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
                   exmem_write_o, memwb_bubble_o};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end else begin
            $display("ok   %s got=%0h", tag, act);
        end
    endtask

    // Apply inputs mid-cycle (after the falling edge) and let them settle.
    task automatic drive(input logic s, input logic h, input logic b,
                         input logic r, input logic a);
        @(negedge clk_i);
        start_i = s; hazard_stall_i = h; branch_flush_i = b;
        dmem_req_i = r; dmem_ack_i = a;
        #1;
    endtask

    // Advance past the next rising edge and sample well away from it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'(E_HOLD));
        check("rst_cnts", 32'({stall_cnt_o, flush_cnt_o, wait_cnt_o}), 32'd0);
        check("rst_tmo", 32'(timeout_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // IDLE ignores pipeline inputs and waits for start
        drive(0, 1, 1, 0, 0);
        check("idle_ctrl", 32'(ctrl), 32'(E_HOLD));
        tick();
        check("idle_state", 32'(state_o), 32'd0);
        check("idle_stall_cnt", 32'(stall_cnt_o), 32'd0);
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("start_state", 32'(state_o), 32'd1);
        check("run_normal", 32'(ctrl), 32'(E_NORMAL));

        // Stall beats flush
        drive(0, 1, 1, 0, 0);
        check("stall_ctrl", 32'(ctrl), 32'(E_STALL));
        tick();
        drive(0, 0, 0, 0, 0);
        check("stall_cnt", 32'(stall_cnt_o), 32'd1);
        check("stall_flush_cnt", 32'(flush_cnt_o), 32'd0);

        // Plain flush
        drive(0, 0, 1, 0, 0);
        check("flush_ctrl", 32'(ctrl), 32'(E_FLUSH));
        tick();
        drive(0, 0, 0, 0, 0);
        check("flush_cnt", 32'(flush_cnt_o), 32'd1);

        // Memory wait, ack on the 5th cycle
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0);
            check($sformatf("freeze_ctrl%0d", i), 32'(ctrl), 32'(E_FREEZE));
            tick();
            check($sformatf("freeze_state%0d", i), 32'(state_o), 32'd2);
        end
        drive(0, 0, 0, 1, 1);
        check("ack_ctrl", 32'(ctrl), 32'(E_NORMAL));
        tick();
        drive(0, 0, 0, 0, 0);
        check("ack_state", 32'(state_o), 32'd1);
        check("ack_wait_cnt", 32'(wait_cnt_o), 32'd4);

        // Miss + stall + flush: freeze wins; then req dropped releases
        drive(0, 1, 1, 1, 0);
        check("all3_ctrl", 32'(ctrl), 32'(E_FREEZE));
        tick();
        drive(0, 0, 0, 0, 0);
        check("all3_state", 32'(state_o), 32'd2);
        check("drop_ctrl", 32'(ctrl), 32'(E_NORMAL));
        tick();
        check("drop_state", 32'(state_o), 32'd1);
        check("all3_cnts", 32'({stall_cnt_o, flush_cnt_o, wait_cnt_o}), 32'h115);

        // Ack without req is ignored
        drive(0, 0, 0, 0, 1);
        check("lone_ack_ctrl", 32'(ctrl), 32'(E_NORMAL));
        tick();
        check("lone_ack_state", 32'(state_o), 32'd1);
        check("lone_ack_wait", 32'(wait_cnt_o), 32'd5);

        // Flush counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        check("flush_sat", 32'(flush_cnt_o), 32'd15);
        tick();
        check("flush_sat_hold", 32'(flush_cnt_o), 32'd15);

        // Timeout: entry cycle + 5 MEM_WAIT cycles -> HALT
        drive(0, 0, 0, 1, 0);
        tick();
        check("tmo_enter", 32'(state_o), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("tmo_wait%0d", i), 32'(state_o), 32'd2);
        end
        check("tmo_pre_flag", 32'(timeout_o), 32'd0);
        tick();
        check("tmo_halt", 32'(state_o), 32'd3);
        check("tmo_flag", 32'(timeout_o), 32'd1);
        check("tmo_wait_cnt", 32'(wait_cnt_o), 32'd11);
        check("halt_ctrl", 32'(ctrl), 32'(E_HOLD));
        drive(1, 1, 1, 1, 0);
        tick();
        tick();
        check("halt_persist", 32'(state_o), 32'd3);
        check("halt_no_count", 32'({stall_cnt_o, wait_cnt_o}), 32'h1B);

        // Async reset in the middle of MEM_WAIT
        drive(0, 0, 0, 0, 0);
        rst_i = 1'b0;
        #1;
        check("halt_rst_state", 32'(state_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        tick();
        tick();
        check("pre_arst_state", 32'(state_o), 32'd2);
        check("pre_arst_wait", 32'(wait_cnt_o), 32'd2);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("arst_state", 32'(state_o), 32'd0);
        check("arst_ctrl", 32'(ctrl), 32'(E_HOLD));
        check("arst_cnts", 32'({stall_cnt_o, flush_cnt_o, wait_cnt_o}), 32'd0);
        check("arst_tmo", 32'(timeout_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage RISC-V CPU.
- Merges three stall and flush sources into one consistent set of per-stage write, flush and bubble controls:
  - load-use stall request from the hazard unit;
  - taken-branch flush from ID;
  - data-memory handshake (req/ack) from MEM.
- Owns the start-up hold, the memory-wait freeze FSM, a wait timeout, and saturating event counters for debug.

Parameters:
- CNT_W, 16: width of each event counter.
- TMO_W, 8: width of the memory-wait timer.
- MEM_TIMEOUT, 200: maximum consecutive memory-wait cycles before halting; 0 disables the timeout.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset; asserting it forces IDLE immediately.
- start_i  in  1  leave IDLE (sampled only in IDLE).
- hazard_stall_i  in  1  load-use stall request from the hazard unit.
- branch_flush_i  in  1  taken branch resolved in ID.
- dmem_req_i  in  1  MEM stage holds a load or store.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC register enable.
- ifid_write_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  zero the IF/ID instruction.
- idex_bubble_o  out  1  load NOP control into ID/EX.
- exmem_write_o  out  1  ID/EX and EX/MEM register enable.
- memwb_bubble_o  out  1  load NOP control into MEM/WB.
- state_o  out  2  IDLE=0, RUN=1, MEM_WAIT=2, HALT=3.
- timeout_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  CNT_W  count of load-use stall cycles.
- flush_cnt_o  out  CNT_W  count of branch flush cycles.
- wait_cnt_o  out  CNT_W  count of memory-freeze cycles.

Behaviour:
- Reset, and the outputs in IDLE and HALT:
  - state=IDLE, counters=0, timer=0, timeout_o=0.
  - Outputs: pc/ifid/exmem write=0, ifid_flush_o=0, idex_bubble_o=1, memwb_bubble_o=1.
- IDLE -> RUN on the first rising edge with start_i=1. start_i is ignored in all other states.
- miss = dmem_req_i & ~dmem_ack_i. All outputs are combinational from state and inputs.
- Output priority in RUN and MEM_WAIT is freeze > stall > flush > normal:
  - freeze (miss=1): pc/ifid/exmem write=0, flush=0, idex_bubble_o=0, memwb_bubble_o=1.
  - stall (hazard_stall_i=1): pc/ifid write=0, idex_bubble_o=1, exmem_write_o=1, flush=0, memwb_bubble_o=0. branch_flush_i is ignored because the branch is re-evaluated next cycle.
  - flush (branch_flush_i=1): all writes=1, ifid_flush_o=1, both bubbles=0.
  - normal: all writes=1, flush=0, both bubbles=0.
- RUN:
  - miss=1: next state MEM_WAIT, timer<=1.
  - otherwise: stay in RUN.
- MEM_WAIT:
  - miss=1: remain, timer+1.
  - miss=0 (ack, or req dropped): the non-freeze output priority applies in that same cycle, so the pipeline advances on the ack edge. Next state RUN, timer<=0.
- Timeout: in MEM_WAIT, if MEM_TIMEOUT!=0, miss=1 and timer==MEM_TIMEOUT, then next state is HALT and timeout_o is set.
  - HALT has IDLE-style outputs.
  - HALT exits only via reset.
- Timer saturates at all-ones, so MEM_TIMEOUT must be <= 2^TMO_W-1.
- Counters:
  - Each counter increments by 1 on every cycle its output case wins: stall, flush, or freeze.
  - A freeze cycle in RUN (the entry cycle) counts.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - No counter increments in IDLE or HALT.
- Reset asserted mid-MEM_WAIT: IDLE immediately; counters and the timeout flag clear.
- Simultaneous miss+stall+flush: freeze wins; only wait_cnt_o increments.
- dmem_ack_i without dmem_req_i: ignored.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/RUN/MEM_WAIT/HALT);
  - a pipe_ctrl struct {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_bubble};
  - named constants CTRL_FREEZE, CTRL_STALL, CTRL_FLUSH, CTRL_NORMAL, CTRL_HOLD.
- One sub-module, sat_counter (parameter W; inc, clr, q; asynchronous active-low reset), is instantiated three times.

Test Plan:
- Reset, then start_i=1 for 1 cycle -> state_o 0->1; before start, pc_write_o=0, idex_bubble_o=1; after start, all writes=1.
- RUN, hazard_stall_i=1 for 1 cycle with branch_flush_i=1 -> pc_write_o=0, idex_bubble_o=1, ifid_flush_o=0; stall_cnt_o=1, flush_cnt_o=0.
- dmem_req_i=1, ack arriving 4 cycles later -> freeze for 4 cycles (state_o=2 after the first), release on the ack cycle with writes=1, state_o=1, wait_cnt_o=4.
- MEM_TIMEOUT=5, req held with no ack -> HALT after 5 MEM_WAIT cycles; timeout_o=1; state_o=3 persists until rst_i=0.
- rst_i driven low asynchronously mid-MEM_WAIT (between clock edges) -> outputs reach IDLE values immediately, counters read 0.
- CNT_W=4, 20 flush cycles -> flush_cnt_o=15, held.
